// File: rtl/dcache_pkg.sv
// Purpose: shared types and sizing for the L1 D$ port arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcache_pkg;

  localparam int PLEN            = 32;
  localparam int XLEN            = 32;
  localparam int TAG_W           = 6;
  localparam int DC_TAG_W        = TAG_W + 1;
  localparam int SB_CNT_W        = 5;
  localparam int STARVE_LIMIT    = 8;
  localparam int SB_HIGH_WM      = 12;
  localparam int MAX_OUTSTANDING = 4;

  typedef enum logic [3:0] {
    LSU_LB  = 4'd0,
    LSU_LH  = 4'd1,
    LSU_LW  = 4'd2,
    LSU_LBU = 4'd3,
    LSU_LHU = 4'd4,
    LSU_SB  = 4'd5,
    LSU_SH  = 4'd6,
    LSU_SW  = 4'd7
  } lsu_op_e;

  // One D$ request; tag is {epoch, rob_tag} for loads and zero for stores.
  typedef struct packed {
    logic                we;
    logic [PLEN-1:0]     addr;
    logic [XLEN-1:0]     data;
    lsu_op_e             op;
    logic [DC_TAG_W-1:0] tag;
  } dc_req_t;

endpackage

// File: rtl/dcache_arb_slot.sv
// Purpose: one-entry valid/ready request register toward the D$, with a kill that drops the held entry.
// Latency: 1 cycle from input acceptance to output valid.
// Backpressure: accepts when empty or when the held entry is taken downstream the same cycle.
module dcache_arb_slot
  import dcache_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    i_in_vld,
  output logic    o_in_rdy,
  input  dc_req_t i_in_dat,
  input  logic    i_kill,
  output logic    o_out_vld,
  input  logic    i_out_rdy,
  output dc_req_t o_out_dat
);

  logic    r_vld;
  dc_req_t r_dat;

  assign o_in_rdy  = !r_vld || i_out_rdy;
  assign o_out_vld = r_vld;
  assign o_out_dat = r_dat;

  // Load a new entry when there is room; otherwise hold, unless the held entry is killed.
  // Payload is untouched on kill so it never glitches while valid is still high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (o_in_rdy) begin
      r_vld <= i_in_vld;
      if (i_in_vld) begin
        r_dat <= i_in_dat;
      end
    end else if (i_kill) begin
      r_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Purpose: shares the L1 D$ request port between loads and store-buffer drain; loads favoured, stores forced on starvation/high SB occupancy.
// Latency: 1 cycle grant-to-D$ through a one-entry slot; load responses are filtered combinationally by epoch.
// Backpressure: ready goes only to the winner, and only when the slot is free or draining; loads also stall at the in-flight limit.
// Optional: define DCACHE_ARB_PERF_EN to add load-grant, store-grant and conflict counters.
module dcache_port_arbiter
  import dcache_pkg::*;
#(
  parameter int STARVE_LIMIT    = dcache_pkg::STARVE_LIMIT,
  parameter int SB_HIGH_WM      = dcache_pkg::SB_HIGH_WM,
  parameter int MAX_OUTSTANDING = dcache_pkg::MAX_OUTSTANDING
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                ld_req_valid_i,
  output logic                ld_req_ready_o,
  input  logic [PLEN-1:0]     ld_req_addr_i,
  input  lsu_op_e             ld_req_op_i,
  input  logic [TAG_W-1:0]    ld_req_tag_i,
  input  logic                st_req_valid_i,
  output logic                st_req_ready_o,
  input  logic [PLEN-1:0]     st_req_addr_i,
  input  logic [XLEN-1:0]     st_req_data_i,
  input  lsu_op_e             st_req_op_i,
  input  logic [SB_CNT_W-1:0] sb_count_i,
  output logic                dc_req_valid_o,
  input  logic                dc_req_ready_i,
  output logic                dc_req_we_o,
  output logic [PLEN-1:0]     dc_req_addr_o,
  output logic [XLEN-1:0]     dc_req_data_o,
  output lsu_op_e             dc_req_op_o,
  output logic [DC_TAG_W-1:0] dc_req_tag_o,
  input  logic                dc_rsp_valid_i,
  input  logic [DC_TAG_W-1:0] dc_rsp_tag_i,
  input  logic [XLEN-1:0]     dc_rsp_data_i,
  output logic                ld_rsp_valid_o,
  output logic [TAG_W-1:0]    ld_rsp_tag_o,
  output logic [XLEN-1:0]    ld_rsp_data_o
`ifdef DCACHE_ARB_PERF_EN
  ,
  output logic [31:0]         perf_ld_grant_o,
  output logic [31:0]         perf_st_grant_o,
  output logic [31:0]         perf_conflict_o
`endif
);

  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [STV_W-1:0] r_starve_cnt;
  logic [OUT_W-1:0] r_outstanding;
  logic             r_epoch;

  logic             w_slot_in_vld;
  logic             w_slot_in_rdy;
  dc_req_t          w_slot_in_dat;
  logic             w_slot_vld;
  dc_req_t          w_slot_dat;
  logic             w_kill;
  logic             w_slot_holds_load;
  logic [OUT_W:0]   w_inflight;
  logic             w_st_prio;
  logic             w_ld_ok;
  logic             w_st_win;
  logic             w_ld_win;
  logic             w_ld_fire;

  // Loads already in the slot count against the in-flight budget even if they fire this cycle.
  assign w_slot_holds_load = w_slot_vld && !w_slot_dat.we;
  assign w_inflight        = (OUT_W+1)'(r_outstanding) + (OUT_W+1)'(w_slot_holds_load);

  assign w_st_prio = (r_starve_cnt == STV_W'(STARVE_LIMIT)) ||
                     (sb_count_i >= SB_CNT_W'(SB_HIGH_WM));
  assign w_ld_ok   = ld_req_valid_i && !flush_i &&
                     (w_inflight < (OUT_W+1)'(MAX_OUTSTANDING));

  // Grants are suppressed in reset so every output reads 0 while rst_i is high.
  assign w_st_win = !rst_i && w_slot_in_rdy && st_req_valid_i && (w_st_prio || !w_ld_ok);
  assign w_ld_win = !rst_i && w_slot_in_rdy && w_ld_ok && !w_st_win;

  assign ld_req_ready_o = w_ld_win;
  assign st_req_ready_o = w_st_win;
  assign w_slot_in_vld  = w_st_win || w_ld_win;

  // A flushed load must not reach the D$; committed stores survive a flush.
  assign w_kill = flush_i && w_slot_holds_load;

  // Build the winning request; loads are stamped with the current epoch.
  always_comb begin
    w_slot_in_dat = '0;
    if (w_st_win) begin
      w_slot_in_dat.we   = 1'b1;
      w_slot_in_dat.addr = st_req_addr_i;
      w_slot_in_dat.data = st_req_data_i;
      w_slot_in_dat.op   = st_req_op_i;
      w_slot_in_dat.tag  = '0;
    end else if (w_ld_win) begin
      w_slot_in_dat.we   = 1'b0;
      w_slot_in_dat.addr = ld_req_addr_i;
      w_slot_in_dat.op   = ld_req_op_i;
      w_slot_in_dat.tag  = {r_epoch, ld_req_tag_i};
    end
  end

  dcache_arb_slot u_slot (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_in_vld  (w_slot_in_vld),
    .o_in_rdy  (w_slot_in_rdy),
    .i_in_dat  (w_slot_in_dat),
    .i_kill    (w_kill),
    .o_out_vld (w_slot_vld),
    .i_out_rdy (dc_req_ready_i),
    .o_out_dat (w_slot_dat)
  );

  assign dc_req_valid_o = w_slot_vld;
  assign dc_req_we_o    = w_slot_dat.we;
  assign dc_req_addr_o  = w_slot_dat.addr;
  assign dc_req_data_o  = w_slot_dat.data;
  assign dc_req_op_o    = w_slot_dat.op;
  assign dc_req_tag_o   = w_slot_dat.tag;

  assign w_ld_fire = dc_req_valid_o && dc_req_ready_i && !dc_req_we_o;

  // Count cycles a waiting store loses; saturate so forced priority holds until it wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_starve_cnt <= '0;
    end else if (!st_req_valid_i || st_req_ready_o) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != STV_W'(STARVE_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + STV_W'(1);
    end
  end

  // Track loads issued to the D$ whose response (any epoch) has not come back.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else begin
      case ({w_ld_fire, dc_rsp_valid_i})
        2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Each flush starts a new epoch so responses of killed loads can be recognised.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_epoch <= 1'b0;
    end else if (flush_i) begin
      r_epoch <= ~r_epoch;
    end
  end

  assign ld_rsp_valid_o = dc_rsp_valid_i && (dc_rsp_tag_i[TAG_W] == r_epoch);
  assign ld_rsp_tag_o   = ld_rsp_valid_o ? dc_rsp_tag_i[TAG_W-1:0] : '0;
  assign ld_rsp_data_o  = ld_rsp_valid_o ? dc_rsp_data_i : '0;

`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] r_perf_ld_grant;
  logic [31:0] r_perf_st_grant;
  logic [31:0] r_perf_conflict;

  // Free-running wrapping event counters for grants and contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_ld_grant <= '0;
      r_perf_st_grant <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (ld_req_ready_o) r_perf_ld_grant <= r_perf_ld_grant + 32'd1;
      if (st_req_ready_o) r_perf_st_grant <= r_perf_st_grant + 32'd1;
      if (ld_req_valid_i && st_req_valid_i) r_perf_conflict <= r_perf_conflict + 32'd1;
    end
  end

  assign perf_ld_grant_o = r_perf_ld_grant;
  assign perf_st_grant_o = r_perf_st_grant;
  assign perf_conflict_o = r_perf_conflict;
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;
  import dcache_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                flush_i;
  logic                ld_req_valid_i;
  logic                ld_req_ready_o;
  logic [PLEN-1:0]     ld_req_addr_i;
  lsu_op_e             ld_req_op_i;
  logic [TAG_W-1:0]    ld_req_tag_i;
  logic                st_req_valid_i;
  logic                st_req_ready_o;
  logic [PLEN-1:0]     st_req_addr_i;
  logic [XLEN-1:0]     st_req_data_i;
  lsu_op_e             st_req_op_i;
  logic [SB_CNT_W-1:0] sb_count_i;
  logic                dc_req_valid_o;
  logic                dc_req_ready_i;
  logic                dc_req_we_o;
  logic [PLEN-1:0]     dc_req_addr_o;
  logic [XLEN-1:0]     dc_req_data_o;
  lsu_op_e             dc_req_op_o;
  logic [DC_TAG_W-1:0] dc_req_tag_o;
  logic                dc_rsp_valid_i;
  logic [DC_TAG_W-1:0] dc_rsp_tag_i;
  logic [XLEN-1:0]     dc_rsp_data_i;
  logic                ld_rsp_valid_o;
  logic [TAG_W-1:0]    ld_rsp_tag_o;
  logic [XLEN-1:0]     ld_rsp_data_o;
`ifdef DCACHE_ARB_PERF_EN
  logic [31:0]         perf_ld_grant_o;
  logic [31:0]         perf_st_grant_o;
  logic [31:0]         perf_conflict_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  dcache_port_arbiter dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .ld_req_valid_i (ld_req_valid_i),
    .ld_req_ready_o (ld_req_ready_o),
    .ld_req_addr_i  (ld_req_addr_i),
    .ld_req_op_i    (ld_req_op_i),
    .ld_req_tag_i   (ld_req_tag_i),
    .st_req_valid_i (st_req_valid_i),
    .st_req_ready_o (st_req_ready_o),
    .st_req_addr_i  (st_req_addr_i),
    .st_req_data_i  (st_req_data_i),
    .st_req_op_i    (st_req_op_i),
    .sb_count_i     (sb_count_i),
    .dc_req_valid_o (dc_req_valid_o),
    .dc_req_ready_i (dc_req_ready_i),
    .dc_req_we_o    (dc_req_we_o),
    .dc_req_addr_o  (dc_req_addr_o),
    .dc_req_data_o  (dc_req_data_o),
    .dc_req_op_o    (dc_req_op_o),
    .dc_req_tag_o   (dc_req_tag_o),
    .dc_rsp_valid_i (dc_rsp_valid_i),
    .dc_rsp_tag_i   (dc_rsp_tag_i),
    .dc_rsp_data_i  (dc_rsp_data_i),
    .ld_rsp_valid_o (ld_rsp_valid_o),
    .ld_rsp_tag_o   (ld_rsp_tag_o),
    .ld_rsp_data_o  (ld_rsp_data_o)
`ifdef DCACHE_ARB_PERF_EN
    ,
    .perf_ld_grant_o(perf_ld_grant_o),
    .perf_st_grant_o(perf_st_grant_o),
    .perf_conflict_o(perf_conflict_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i        = 1'b0;
    ld_req_valid_i = 1'b0;
    ld_req_addr_i  = '0;
    ld_req_op_i    = LSU_LW;
    ld_req_tag_i   = '0;
    st_req_valid_i = 1'b0;
    st_req_addr_i  = '0;
    st_req_data_i  = '0;
    st_req_op_i    = LSU_SW;
    sb_count_i     = '0;
    dc_req_ready_i = 1'b0;
    dc_rsp_valid_i = 1'b0;
    dc_rsp_tag_i   = '0;
    dc_rsp_data_i  = '0;
  endtask

  // Reset for one edge, then release with idle inputs; returns at the start of cycle 0.
  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    nxt();
    rst_i = 1'b0;
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    idle();
    rst_i          = 1'b1;
    ld_req_valid_i = 1'b1;
    st_req_valid_i = 1'b1;
    nxt();
    #4;
    chk("rst_dc_valid", dc_req_valid_o, 0);
    chk("rst_ld_ready", ld_req_ready_o, 0);
    chk("rst_st_ready", st_req_ready_o, 0);
    chk("rst_dc_tag",   dc_req_tag_o,   0);
    chk("rst_rsp_vld",  ld_rsp_valid_o, 0);
    nxt();
    rst_i = 1'b0;
    idle();

    // ---------------- loads only, in-flight limit ----------------
    dc_req_ready_i = 1'b1;
    ld_req_valid_i = 1'b1;
    ld_req_tag_i = 6'd1; ld_req_addr_i = 32'h1000;
    #4;
    chk("l_c0_ld_rdy", ld_req_ready_o, 1);
    chk("l_c0_dc_vld", dc_req_valid_o, 0);
    nxt();
    ld_req_tag_i = 6'd2; ld_req_addr_i = 32'h1008;
    #4;
    chk("l_c1_ld_rdy", ld_req_ready_o, 1);
    chk("l_c1_dc_vld", dc_req_valid_o, 1);
    chk("l_c1_dc_we",  dc_req_we_o,    0);
    chk("l_c1_dc_tag", dc_req_tag_o,   7'h01);
    chk("l_c1_dc_adr", dc_req_addr_o,  32'h1000);
    nxt();
    ld_req_tag_i = 6'd3; ld_req_addr_i = 32'h1010;
    #4;
    chk("l_c2_ld_rdy", ld_req_ready_o, 1);
    chk("l_c2_dc_tag", dc_req_tag_o,   7'h02);
    nxt();
    ld_req_tag_i = 6'd4; ld_req_addr_i = 32'h1018;
    #4;
    chk("l_c3_ld_rdy", ld_req_ready_o, 1);
    chk("l_c3_dc_tag", dc_req_tag_o,   7'h03);
    nxt();
    ld_req_tag_i = 6'd5; ld_req_addr_i = 32'h1020;
    #4;
    chk("l_c4_ld_stall", ld_req_ready_o, 0);
    chk("l_c4_dc_tag",   dc_req_tag_o,   7'h04);
    nxt();
    #4;
    chk("l_c5_ld_stall", ld_req_ready_o, 0);
    chk("l_c5_dc_vld",   dc_req_valid_o, 0);
    chk("l_c5_outst",    dut.r_outstanding, 4);
    nxt();
    dc_rsp_valid_i = 1'b1; dc_rsp_tag_i = 7'h01; dc_rsp_data_i = 32'hCAFE0001;
    #4;
    chk("l_c6_rsp_vld",  ld_rsp_valid_o, 1);
    chk("l_c6_rsp_tag",  ld_rsp_tag_o,   6'd1);
    chk("l_c6_rsp_dat",  ld_rsp_data_o,  32'hCAFE0001);
    chk("l_c6_ld_stall", ld_req_ready_o, 0);
    nxt();
    dc_rsp_valid_i = 1'b0;
    #4;
    chk("l_c7_ld_rdy", ld_req_ready_o, 1);
    nxt();
    // Slot load fires while a response returns: count must stay at 3.
    ld_req_valid_i = 1'b0;
    dc_rsp_valid_i = 1'b1; dc_rsp_tag_i = 7'h02; dc_rsp_data_i = 32'hCAFE0002;
    #4;
    chk("l_c8_dc_vld", dc_req_valid_o, 1);
    chk("l_c8_dc_tag", dc_req_tag_o,   7'h05);
    chk("l_c8_outst",  dut.r_outstanding, 3);
    nxt();
    dc_rsp_valid_i = 1'b0;
    ld_req_valid_i = 1'b1; ld_req_tag_i = 6'd6;
    #4;
    chk("l_c9_outst",  dut.r_outstanding, 3);
    chk("l_c9_ld_rdy", ld_req_ready_o, 1);
    nxt();

    // ---------------- anti-starvation ----------------
    do_reset();
    dc_req_ready_i = 1'b1;
    sb_count_i     = 5'd3;
    st_req_valid_i = 1'b1; st_req_addr_i = 32'h2000; st_req_data_i = 32'h55AA1234;
    st_req_op_i    = LSU_SW;
    ld_req_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ld_req_tag_i   = 6'(16 + i);
      dc_rsp_valid_i = (i >= 2);
      dc_rsp_tag_i   = 7'h10;
      #4;
      chk($sformatf("s_c%0d_ld_rdy", i), ld_req_ready_o, 1);
      chk($sformatf("s_c%0d_st_rdy", i), st_req_ready_o, 0);
      nxt();
    end
    ld_req_tag_i = 6'd24;
    #4;
    chk("s_c8_st_rdy", st_req_ready_o, 1);
    chk("s_c8_ld_rdy", ld_req_ready_o, 0);
    nxt();
    dc_rsp_valid_i = 1'b0;
    #4;
    chk("s_c9_dc_we",  dc_req_we_o,    1);
    chk("s_c9_dc_adr", dc_req_addr_o,  32'h2000);
    chk("s_c9_dc_dat", dc_req_data_o,  32'h55AA1234);
    chk("s_c9_dc_tag", dc_req_tag_o,   0);
    chk("s_c9_ld_rdy", ld_req_ready_o, 1);
    chk("s_c9_st_rdy", st_req_ready_o, 0);
    nxt();

    // ---------------- SB high watermark ----------------
    do_reset();
    dc_req_ready_i = 1'b1;
    ld_req_valid_i = 1'b1; ld_req_tag_i = 6'd7;
    st_req_valid_i = 1'b1; st_req_addr_i = 32'h3000;
    sb_count_i     = 5'd11;
    #4;
    chk("w_11_ld_rdy", ld_req_ready_o, 1);
    chk("w_11_st_rdy", st_req_ready_o, 0);
    nxt();
    sb_count_i = 5'd12;
    #4;
    chk("w_12_st_rdy", st_req_ready_o, 1);
    chk("w_12_ld_rdy", ld_req_ready_o, 0);
    nxt();

    // ---------------- flush kills load in slot ----------------
    do_reset();
    dc_req_ready_i = 1'b1;
    ld_req_valid_i = 1'b1; ld_req_tag_i = 6'd3;
    #4;
    chk("f_c0_ld_rdy", ld_req_ready_o, 1);
    nxt();
    ld_req_tag_i = 6'd5;
    #4;
    chk("f_c1_ld_rdy", ld_req_ready_o, 1);
    nxt();
    dc_req_ready_i = 1'b0;
    flush_i        = 1'b1;
    ld_req_tag_i   = 6'd7;
    #4;
    chk("f_c2_dc_vld", dc_req_valid_o, 1);
    chk("f_c2_dc_tag", dc_req_tag_o,   7'h05);
    chk("f_c2_ld_rdy", ld_req_ready_o, 0);
    nxt();
    flush_i        = 1'b0;
    ld_req_valid_i = 1'b0;
    dc_rsp_valid_i = 1'b1; dc_rsp_tag_i = 7'h03; dc_rsp_data_i = 32'hDEAD0003;
    #4;
    chk("f_c3_dc_vld",  dc_req_valid_o, 0);
    chk("f_c3_rsp_vld", ld_rsp_valid_o, 0);
    nxt();
    dc_rsp_valid_i = 1'b0;
    dc_req_ready_i = 1'b1;
    ld_req_valid_i = 1'b1; ld_req_tag_i = 6'd9;
    #4;
    chk("f_c4_ld_rdy", ld_req_ready_o, 1);
    nxt();
    ld_req_valid_i = 1'b0;
    #4;
    chk("f_c5_dc_tag", dc_req_tag_o, 7'h49);
    nxt();

    // ---------------- flush keeps store in slot ----------------
    do_reset();
    st_req_valid_i = 1'b1; st_req_addr_i = 32'h4440; st_req_data_i = 32'h0BADF00D;
    sb_count_i     = 5'd1;
    #4;
    chk("k_c0_st_rdy", st_req_ready_o, 1);
    nxt();
    st_req_valid_i = 1'b0;
    flush_i        = 1'b1;
    ld_req_valid_i = 1'b1; ld_req_tag_i = 6'd2;
    #4;
    chk("k_c1_dc_vld", dc_req_valid_o, 1);
    chk("k_c1_dc_we",  dc_req_we_o,    1);
    chk("k_c1_ld_rdy", ld_req_ready_o, 0);
    nxt();
    flush_i        = 1'b0;
    ld_req_valid_i = 1'b0;
    dc_req_ready_i = 1'b1;
    #4;
    chk("k_c2_dc_vld", dc_req_valid_o, 1);
    chk("k_c2_dc_adr", dc_req_addr_o,  32'h4440);
    chk("k_c2_dc_dat", dc_req_data_o,  32'h0BADF00D);
    chk("k_c2_dc_tag", dc_req_tag_o,   0);
    nxt();
    #4;
    chk("k_c3_dc_vld", dc_req_valid_o, 0);
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
